// File: rtl/wired_bus_if.sv
// Bundle of driver, FIFO-handshake and status signals for the wired bus resolver.
// The resolver connects through the slave modport and its driver/consumer through the master modport.
interface wired_bus_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NCH-1:0]       drv_en;
  logic [NCH*WIDTH-1:0] drv_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [WIDTH-1:0]     bus_level;
  logic                 conflict;
  logic [15:0]          conflict_cnt;
  logic                 overflow;
  logic [LW-1:0]        level;

  modport master (
    output drv_en, drv_data, out_ready,
    input  out_valid, out_data, bus_level, conflict, conflict_cnt, overflow, level
  );

  modport slave (
    input  drv_en, drv_data, out_ready,
    output out_valid, out_data, bus_level, conflict, conflict_cnt, overflow, level
  );
endinterface

// File: rtl/wired_bus_resolver.sv
// Resolves several enabled drivers onto one wired-OR/AND/tri bus word and queues each
// resolved word in a small FIFO, with tri-state contention and overflow reporting.
module wired_bus_resolver #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0,
  parameter int PULL  = 0
) (
  input  logic       clk,
  input  logic       rst,
  wired_bus_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [WIDTH-1:0] PULL_V   = (PULL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WIDTH-1:0] or_w, and_w, res_w;
  logic             evt_w, contend_w;

  // In tri mode the resolved word is always the OR: a single driver or identical
  // drivers make OR equal to their data, and contention is OR differing from AND.
  always_comb begin
    or_w  = '0;
    and_w = '1;
    for (int i = 0; i < NCH; i++) begin
      if (bus.drv_en[i]) begin
        or_w  = or_w  | bus.drv_data[i*WIDTH +: WIDTH];
        and_w = and_w & bus.drv_data[i*WIDTH +: WIDTH];
      end
    end
    evt_w     = |bus.drv_en;
    contend_w = (MODE == 2) && evt_w && (or_w != and_w);
    res_w     = (MODE == 1) ? and_w : or_w;
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [WIDTH-1:0] bl_q, bl_d;
  logic             cf_q, cf_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic             pop_w, full_w, push_w, drop_w;

  // A pop in the same cycle frees the slot a full FIFO needs for the incoming word.
  always_comb begin
    pop_w  = (lvl_q != '0) && bus.out_ready;
    full_w = (lvl_q == FULL_LVL);
    push_w = evt_w && (!full_w || pop_w);
    drop_w = evt_w && full_w && !pop_w;
    wr_d   = push_w ? wr_q + 1'b1 : wr_q;
    rd_d   = pop_w  ? rd_q + 1'b1 : rd_q;
    lvl_d  = lvl_q + LW'(push_w) - LW'(pop_w);
    bl_d   = evt_w ? res_w : PULL_V;
    cf_d   = contend_w;
    cnt_d  = contend_w ? sat_inc16(cnt_q) : cnt_q;
    ov_d   = ov_q | drop_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      bl_q  <= PULL_V;
      cf_q  <= 1'b0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      bl_q  <= bl_d;
      cf_q  <= cf_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_w) mem_q[wr_q] <= res_w;
  end

  assign bus.out_valid    = (lvl_q != '0);
  assign bus.out_data     = (lvl_q != '0) ? mem_q[rd_q] : '0;
  assign bus.bus_level    = bl_q;
  assign bus.conflict     = cf_q;
  assign bus.conflict_cnt = cnt_q;
  assign bus.overflow     = ov_q;
  assign bus.level        = lvl_q;
endmodule

// File: doc/wired_bus_resolver.md
WIRED_BUS_RESOLVER -- requirements
Module: wired_bus_resolver

Interface
REQ-001 SHALL have parameter NCH, default 4, number of driving channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per channel (1..64).
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-004 SHALL have parameter MODE, default 0, resolution mode: 0=wor, 1=wand, 2=tri (exclusive driver).
REQ-005 SHALL have parameter PULL, default 0, idle value when no channel drives: 0=all-zeros (tri0), 1=all-ones (tri1).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 drv_en  input  NCH  per-channel drive enable.
REQ-009 drv_data  input  NCH*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  FIFO head holds a resolved word.
REQ-011 out_ready  input  1  consumer accepts head when high with out_valid.
REQ-012 out_data  output  WIDTH  resolved word at FIFO head.
REQ-013 bus_level  output  WIDTH  registered last resolved value, PULL value when idle.
REQ-014 conflict  output  1  one-cycle pulse: tri-mode contention detected on the previous cycle.
REQ-015 conflict_cnt  output  16  saturating count of contention cycles.
REQ-016 overflow  output  1  sticky: a resolved word was dropped because FIFO full.
REQ-017 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Resolution SHALL be combinational over enabled channels only; disabled channels contribute nothing.
REQ-019 MODE 0: resolved = bitwise OR of enabled channel data.
REQ-020 MODE 1: resolved = bitwise AND of enabled channel data.
REQ-021 MODE 2: one enabled channel -> its data; more than one enabled with any differing bit -> contention, resolved = bitwise OR; more than one enabled with identical data -> that data, no contention.
REQ-022 No channel enabled: no resolution event; bus_level SHALL load the PULL value.
REQ-023 A resolution event (any drv_en bit high) SHALL register the resolved word into bus_level and push it into the FIFO one cycle later (latency 1 clk from drv_en to out_valid when FIFO empty).
REQ-024 conflict SHALL assert for exactly the cycle after a contention cycle; conflict_cnt SHALL increment by 1 per contention cycle and saturate at 16'hFFFF.
REQ-025 In MODE 0 and 1, conflict and conflict_cnt SHALL stay 0.
REQ-026 FIFO handshake: pop occurs when out_valid && out_ready; out_data SHALL be stable while out_valid && !out_ready.
REQ-027 Simultaneous push and pop SHALL be accepted when full or empty-with-bypass disallowed: when full, a pop in the same cycle frees space so the push succeeds; when empty, push is visible next cycle (no combinational bypass).
REQ-028 Push when full with no pop SHALL drop the word, leave FIFO unchanged, and set overflow until reset.
REQ-029 Read/write pointers SHALL wrap modulo DEPTH; level SHALL equal pushes minus pops, range 0..DEPTH.
REQ-030 out_valid SHALL equal (level != 0).

Reset
REQ-031 While rst high at a clock edge: FIFO emptied (level=0, out_valid=0), out_data=0, bus_level=PULL value, conflict=0, conflict_cnt=0, overflow=0.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents and any pending push from that cycle; drv_en is ignored during reset.
REQ-033 First resolution event SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-034 MODE=0, NCH=4, WIDTH=8: drv_en=4'b0101, ch0=8'h0F, ch2=8'hA0 -> next cycle out_valid=1, out_data=8'hAF, bus_level=8'hAF.
REQ-035 MODE=1: drv_en=4'b0011, ch0=8'hF3, ch1=8'h3F -> out_data=8'h33; then drv_en=0 with PULL=1 -> bus_level=8'hFF, no push.
REQ-036 MODE=2: drv_en=4'b1001, ch0=8'h12, ch3=8'h34 for 3 cycles -> conflict pulses each following cycle, conflict_cnt=3, out_data=8'h36; identical data 8'h55 on two channels -> no conflict.
REQ-037 DEPTH=4, out_ready=0, 5 consecutive events -> level=4, overflow=1, FIFO holds first 4 words in order; then out_ready=1 -> 4 words drained in order, out_valid drops.
REQ-038 FIFO full, push and pop same cycle -> level stays 4, no overflow, new word at tail.
REQ-039 rst asserted with level=3 and conflict_cnt=7 -> next cycle level=0, out_valid=0, conflict_cnt=0, overflow=0, bus_level=PULL value.
